// File: rtl/pll_nco_clken_gen.sv
`default_nettype none
// ============================================================================
// Module   : pll_nco_clken_gen
// Brief    : Multi-channel NCO clock-enable synthesiser with PLL-style lock
//            indication and runtime-reprogrammable ratios. Define
//            PHASE_OFFSET_EN to add per-channel programmable start phases.
// Revision : 1.0 - initial release
// ============================================================================
module pll_nco_clken_gen #(
    parameter int NUM_CH      = 2,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 64,
    parameter logic [NUM_CH*ACC_W-1:0] INC_INIT   = {32'h44444445, 32'h88888889},
    parameter logic [NUM_CH*ACC_W-1:0] PHASE_INIT = '0
) (
    input  logic                      refclk_i,
    input  logic                      rst_n_i,
    input  logic                      cfg_valid_i,
    output logic                      cfg_ready_o,
    input  logic [$clog2(NUM_CH):0]   cfg_ch_i,
    input  logic [ACC_W-1:0]          cfg_inc_i,
    input  logic [ACC_W-1:0]          cfg_phase_i,
    output logic                      cfg_err_o,
    output logic [NUM_CH-1:0]         clken_o,
    output logic                      locked_o
);

    localparam int c_CH_W  = $clog2(NUM_CH) + 1;
    localparam int c_CNT_W = $clog2(LOCK_CYCLES) + 1;

    typedef enum logic [0:0] {
        ST_SETTLE = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [c_CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]       acc_q [NUM_CH];
    logic [ACC_W-1:0]       acc_d [NUM_CH];
    logic [ACC_W-1:0]       inc_q [NUM_CH];
    logic [ACC_W-1:0]       inc_d [NUM_CH];
    logic [NUM_CH-1:0]      clken_q, clken_d;
    logic                   locked_q, locked_d;
    logic                   cfg_err_q, cfg_err_d;

    logic [ACC_W-1:0]       w_start [NUM_CH];
    logic [ACC_W:0]         w_sum   [NUM_CH];
    logic                   w_accept;
    logic                   w_ch_ok;
    logic                   w_write;

`ifdef PHASE_OFFSET_EN
    logic [ACC_W-1:0]       ph_q [NUM_CH];
    logic [ACC_W-1:0]       ph_d [NUM_CH];
`else
    logic                   w_unused_phase;
    assign w_unused_phase = ^{cfg_phase_i, PHASE_INIT};
`endif

    // Configuration decode: writes land only while locked and in range
    always_comb begin
        w_accept = cfg_valid_i && (state_q == ST_LOCKED);
        w_ch_ok  = (cfg_ch_i < c_CH_W'(NUM_CH));
        w_write  = w_accept && w_ch_ok;
        for (int i = 0; i < NUM_CH; i++) begin
            inc_d[i] = inc_q[i];
            if (w_write && (cfg_ch_i == c_CH_W'(i))) begin
                inc_d[i] = cfg_inc_i;
            end
        end
`ifdef PHASE_OFFSET_EN
        for (int i = 0; i < NUM_CH; i++) begin
            ph_d[i] = ph_q[i];
            if (w_write && (cfg_ch_i == c_CH_W'(i))) begin
                ph_d[i] = cfg_phase_i;
            end
        end
`endif
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        assign w_sum[g] = {1'b0, acc_q[g]} + {1'b0, inc_q[g]};
`ifdef PHASE_OFFSET_EN
        assign w_start[g] = ph_d[g];
`else
        assign w_start[g] = '0;
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clken_d   = '0;
        cfg_err_d = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i] = acc_q[i];
        end
        case (state_q)
            ST_SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                for (int i = 0; i < NUM_CH; i++) begin
                    acc_d[i] = w_start[i];
                end
                if (cnt_q == c_CNT_W'(LOCK_CYCLES - 1)) begin
                    state_d = ST_LOCKED;
                    cnt_d   = '0;
                end
            end
            ST_LOCKED: begin
                if (w_write) begin
                    // A new ratio re-aligns every channel to its start phase
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                    for (int i = 0; i < NUM_CH; i++) begin
                        acc_d[i] = w_start[i];
                    end
                end else begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        acc_d[i]   = w_sum[i][ACC_W-1:0];
                        clken_d[i] = w_sum[i][ACC_W];
                    end
                    cfg_err_d = w_accept && !w_ch_ok;
                end
            end
            default: begin
                state_d = ST_SETTLE;
            end
        endcase
    end

    assign locked_d = (state_d == ST_LOCKED);

    always_ff @(posedge refclk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_SETTLE;
            cnt_q     <= '0;
            clken_q   <= '0;
            locked_q  <= 1'b0;
            cfg_err_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                inc_q[i] <= INC_INIT[i*ACC_W +: ACC_W];
`ifdef PHASE_OFFSET_EN
                ph_q[i]  <= PHASE_INIT[i*ACC_W +: ACC_W];
`endif
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clken_q   <= clken_d;
            locked_q  <= locked_d;
            cfg_err_q <= cfg_err_d;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
                inc_q[i] <= inc_d[i];
`ifdef PHASE_OFFSET_EN
                ph_q[i]  <= ph_d[i];
`endif
            end
        end
    end

    assign cfg_ready_o = (state_q == ST_LOCKED);
    assign cfg_err_o   = cfg_err_q;
    assign clken_o     = clken_q;
    assign locked_o    = locked_q;

endmodule
`default_nettype wire
